instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of InstructionMemory. It owns the program counter, drives PC to the instruction memory and captures the returned 16-bit Instruction into the IF/ID pipeline register for the decoder. It handles stall, branch redirect with flush, and HALT detection. Memory is byte-addressed and instructions are 16 bits wide, so the PC steps by 2.

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit_if_id_register.sv | 43 ++++
 rtl/instruction_fetch_unit.sv | 90 +++++++++
 tb/tb_instruction_fetch_unit.sv | 122 ++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: state encoding, word constants
// and the PC alignment helper.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD  = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;
  localparam logic [ADDR_W-1:0]  PC_STEP   = 16'd2;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  // Instructions are halfword aligned; an odd redirect is rounded down.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory read path, decode-side controls and the
// IF/ID register outputs.
interface instruction_fetch_unit_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0] Instruction;
  logic               Stall;
  logic               BranchTaken;
  logic [ADDR_W-1:0]  BranchTarget;
  logic [ADDR_W-1:0]  PC;
  logic [INSTR_W-1:0] IF_ID_Instruction;
  logic [ADDR_W-1:0]  IF_ID_PCPlus2;
  logic               IF_ID_Valid;
  logic               Halted;

  modport master (
    input  Instruction, Stall, BranchTaken, BranchTarget,
    output PC, IF_ID_Instruction, IF_ID_PCPlus2, IF_ID_Valid, Halted
  );

  modport slave (
    output Instruction, Stall, BranchTaken, BranchTarget,
    input  PC, IF_ID_Instruction, IF_ID_PCPlus2, IF_ID_Valid, Halted
  );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register. Flush inserts a NOP bubble, invalidate only drops the
// valid flag, load captures a new instruction; otherwise contents hold.
module if_id_register
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               invalidate_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pcplus2_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pcplus2_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pcplus2_q;
  logic               valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q   <= '0;
      pcplus2_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pcplus2_q <= pcplus2_i;
      valid_q   <= 1'b1;
    end else if (invalidate_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus2_o = pcplus2_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC and the BOOT/RUN/HALTED sequencer, resolves
// branch > stall > halt > sequential priority and feeds the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'd0,
  parameter logic [15:0] HALT_WORD = cpu_pkg::HALT_WORD,
  parameter logic [15:0] PC_STEP   = cpu_pkg::PC_STEP
) (
  input  logic                      Clock,
  input  logic                      Reset,
  instruction_fetch_unit_if.master  bus
);
  import cpu_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              load, flush, invalidate;
  logic [ADDR_W-1:0] pc_next_seq;

  assign pc_next_seq = pc_q + PC_STEP;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    halted_d   = halted_q;
    load       = 1'b0;
    flush      = 1'b0;
    invalidate = 1'b0;
    unique case (state_q)
      BOOT: begin
        invalidate = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (bus.BranchTaken) begin
          pc_d  = align_pc(bus.BranchTarget);
          flush = 1'b1;
        end else if (bus.Stall) begin
          // hold everything
        end else if (bus.Instruction == HALT_WORD) begin
          load    = 1'b1;
          state_d = HALTED;
        end else begin
          load = 1'b1;
          pc_d = pc_next_seq;
        end
      end
      HALTED: begin
        // Halted rises on the first HALTED edge, one cycle after HALT is captured.
        invalidate = 1'b1;
        halted_d   = 1'b1;
        if (bus.BranchTaken) begin
          pc_d     = align_pc(bus.BranchTarget);
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  if_id_register u_if_id (
    .clk_i        (Clock),
    .rst_ni       (Reset),
    .load_i       (load),
    .flush_i      (flush),
    .invalidate_i (invalidate),
    .instr_i      (bus.Instruction),
    .pcplus2_i    (pc_next_seq),
    .instr_o      (bus.IF_ID_Instruction),
    .pcplus2_o    (bus.IF_ID_PCPlus2),
    .valid_o      (bus.IF_ID_Valid)
  );

  assign bus.PC     = pc_q;
  assign bus.Halted = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural instruction memory.
module tb_instruction_fetch_unit;

  logic Clock;
  logic Reset;
  int   checks;
  int   passed;

  logic [15:0] mem [0:32767];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC  (16'd0),
    .HALT_WORD (16'hFFFF),
    .PC_STEP   (16'd2)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.Instruction = mem[bus.PC[15:1]];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                        input logic [15:0] p2, input logic v, input logic h);
    chk({tag, ".pc"}, bus.PC, pc);
    chk({tag, ".instr"}, bus.IF_ID_Instruction, ins);
    chk({tag, ".pcplus2"}, bus.IF_ID_PCPlus2, p2);
    chk({tag, ".valid"}, {15'd0, bus.IF_ID_Valid}, {15'd0, v});
    chk({tag, ".halted"}, {15'd0, bus.Halted}, {15'd0, h});
  endtask

  initial begin
    checks = 0;
    passed = 0;
    for (int unsigned i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]      = 16'h1111;
    mem[1]      = 16'h2222;
    mem[9]      = 16'hFFFF;   // HALT at byte address 18
    mem[16'h7FFF] = 16'hABCD; // byte address 0xFFFE

    Reset            = 1'b0;
    bus.Stall        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 16'h0000;

    #12;
    chk_if("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    Reset = 1'b1;

    step(); chk_if("boot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_if("fetch0", 16'h0002, 16'h1111, 16'h0002, 1'b1, 1'b0);
    step(); chk_if("fetch2", 16'h0004, 16'h2222, 16'h0004, 1'b1, 1'b0);
    step(); step(); step();
    chk_if("fetch8", 16'h000A, 16'h1004, 16'h000A, 1'b1, 1'b0);

    bus.Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_if("stall", 16'h000A, 16'h1004, 16'h000A, 1'b1, 1'b0);
    end
    bus.Stall = 1'b0;
    step(); chk_if("resume", 16'h000C, 16'h1005, 16'h000C, 1'b1, 1'b0);
    step(); chk_if("fetch12", 16'h000E, 16'h1006, 16'h000E, 1'b1, 1'b0);

    // branch wins over stall, odd target aligned down
    bus.Stall = 1'b1; bus.BranchTaken = 1'b1; bus.BranchTarget = 16'h0031;
    step(); chk_if("branch", 16'h0030, 16'h0000, 16'h000E, 1'b0, 1'b0);
    bus.Stall = 1'b0; bus.BranchTaken = 1'b0;
    step(); chk_if("target", 16'h0032, 16'h1018, 16'h0032, 1'b1, 1'b0);

    bus.BranchTaken = 1'b1; bus.BranchTarget = 16'h0012;
    step(); chk_if("br_to_halt", 16'h0012, 16'h0000, 16'h0032, 1'b0, 1'b0);
    // branch while HALT word is at PC: branch wins, HALT not captured
    step(); chk_if("br_over_halt", 16'h0012, 16'h0000, 16'h0032, 1'b0, 1'b0);
    bus.BranchTaken = 1'b0;
    step(); chk_if("halt_cap", 16'h0012, 16'hFFFF, 16'h0014, 1'b1, 1'b0);
    bus.Stall = 1'b1;
    step(); chk_if("halted", 16'h0012, 16'hFFFF, 16'h0014, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(); chk_if("halt_hold", 16'h0012, 16'hFFFF, 16'h0014, 1'b0, 1'b1);
    end
    bus.Stall = 1'b0; bus.BranchTaken = 1'b1; bus.BranchTarget = 16'h0040;
    step(); chk_if("unhalt", 16'h0040, 16'hFFFF, 16'h0014, 1'b0, 1'b0);
    bus.BranchTaken = 1'b0;
    step(); chk_if("fetch40", 16'h0042, 16'h1020, 16'h0042, 1'b1, 1'b0);

    bus.BranchTaken = 1'b1; bus.BranchTarget = 16'hFFFF;
    step(); chk_if("br_fffe", 16'hFFFE, 16'h0000, 16'h0042, 1'b0, 1'b0);
    bus.BranchTaken = 1'b0;
    step(); chk_if("wrap", 16'h0000, 16'hABCD, 16'h0000, 1'b1, 1'b0);

    bus.BranchTaken = 1'b1; bus.BranchTarget = 16'h000A;
    step(); chk_if("br_10", 16'h000A, 16'h0000, 16'h0000, 1'b0, 1'b0);
    bus.BranchTaken = 1'b0;
    step(); chk_if("run12", 16'h000C, 16'h1005, 16'h000C, 1'b1, 1'b0);

    #3 Reset = 1'b0;
    #1 chk_if("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1 Reset = 1'b1;
    step(); chk_if("reboot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(); chk_if("refetch0", 16'h0002, 16'h1111, 16'h0002, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
